// File: rtl/mm_ctrl_pkg.sv
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and constants for the matrix-multiply sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mm_pkg;

    localparam int SIZE_W = 2;
    localparam int ACC_W  = 20;
    localparam int OUT_AW = 4;

    localparam int signed SAT_MAX = 32767;
    localparam int signed SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mm_ctrl_if.sv
// ============================================================================
//  Module      : mm_ctrl_if
//  Description : Command, datapath and result-memory signals of mm_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mm_ctrl_if #(
    parameter int OUT_AW = 4,
    parameter int ACC_W  = 20
);
    logic              start;
    logic [1:0]        M1_row_size;
    logic [1:0]        M1_col_size;
    logic [1:0]        M2_row_size;
    logic [1:0]        M2_col_size;
    logic [1:0]        ma_col_idx;
    logic [ACC_W-1:0]  ma_out_data;
    logic              Mul_Adder_active;
    logic [1:0]        ma_M1_col_size;
    logic [1:0]        ma_M2_col_size;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic [ACC_W-1:0]  out_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, M1_row_size, M1_col_size, M2_row_size, M2_col_size,
        input  ma_col_idx, ma_out_data,
        output Mul_Adder_active, ma_M1_col_size, ma_M2_col_size,
        output out_we, out_addr, out_wdata, busy, done, err
    );

    modport slave (
        output start, M1_row_size, M1_col_size, M2_row_size, M2_col_size,
        output ma_col_idx, ma_out_data,
        input  Mul_Adder_active, ma_M1_col_size, ma_M2_col_size,
        input  out_we, out_addr, out_wdata, busy, done, err
    );

endinterface

`default_nettype wire

// File: rtl/mm_sat.sv
// ============================================================================
//  Module      : mm_sat
//  Description : Clamps a signed accumulator value to the signed 16-bit range.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mm_sat #(
    parameter int ACC_W = 20
) (
    input  wire logic [ACC_W-1:0] i_din,
    output logic      [ACC_W-1:0] o_dout
);
    import mm_pkg::*;

    always_comb begin
        o_dout = i_din;
        if ($signed(i_din) > SAT_MAX) begin
            o_dout = ACC_W'(SAT_MAX);
        end else if ($signed(i_din) < SAT_MIN) begin
            o_dout = ACC_W'(SAT_MIN);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mm_ctrl.sv
// ============================================================================
//  Module      : mm_ctrl
//  Description : Matrix-multiply sequencer: size check, datapath enable and
//                row-major result writes. Define MM_CTRL_SAT_EN to saturate
//                written results to signed 16-bit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mm_ctrl #(
    parameter int OUT_AW = 4,
    parameter int ACC_W  = 20
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mm_ctrl_if.master  bus
);
    import mm_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_m1_row;
    logic [1:0]        r_m1_col;
    logic [1:0]        r_m2_row;
    logic [1:0]        r_m2_col;
    logic [OUT_AW-1:0] r_total;
    logic [OUT_AW-1:0] r_cnt;
    logic              w_active;
    logic              w_we;
    logic              w_size_err;
    logic              w_last;
    logic [ACC_W-1:0]  w_data_sel;

    assign w_size_err = (r_m1_row == 2'd0) || (r_m1_col == 2'd0) ||
                        (r_m2_row == 2'd0) || (r_m2_col == 2'd0) ||
                        (r_m1_col != r_m2_row);
    assign w_active   = (r_state == COMPUTE);
    // A dot product is complete once the datapath column index reaches the
    // latched column count (one cycle past the last accumulate).
    assign w_we       = w_active && (bus.ma_col_idx == r_m1_col);
    assign w_last     = (r_cnt == r_total - OUT_AW'(1));

`ifdef MM_CTRL_SAT_EN
    mm_sat #(.ACC_W(ACC_W)) u_sat (
        .i_din  (bus.ma_out_data),
        .o_dout (w_data_sel)
    );
`else
    assign w_data_sel = bus.ma_out_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_m1_row <= 2'd0;
            r_m1_col <= 2'd0;
            r_m2_row <= 2'd0;
            r_m2_col <= 2'd0;
            r_total  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && bus.start) begin
                r_m1_row <= bus.M1_row_size;
                r_m1_col <= bus.M1_col_size;
                r_m2_row <= bus.M2_row_size;
                r_m2_col <= bus.M2_col_size;
            end
            if (r_state == CHECK) begin
                r_total <= OUT_AW'(r_m1_row) * OUT_AW'(r_m2_col);
            end
            if (r_state == DONE) begin
                r_cnt <= '0;
            end else if (w_we) begin
                r_cnt <= r_cnt + OUT_AW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = CHECK;
            CHECK:   w_next = w_size_err ? IDLE : COMPUTE;
            COMPUTE: if (w_we && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.Mul_Adder_active = w_active;
    assign bus.ma_M1_col_size   = r_m1_col;
    assign bus.ma_M2_col_size   = r_m2_col;
    assign bus.out_we           = w_we;
    assign bus.out_addr         = r_cnt;
    assign bus.out_wdata        = w_active ? w_data_sel : '0;
    assign bus.busy             = (r_state != IDLE);
    assign bus.done             = (r_state == DONE);
    assign bus.err              = (r_state == CHECK) && w_size_err;

endmodule

`default_nettype wire

// File: tb/tb_mm_ctrl.sv
// ============================================================================
//  Module      : tb_mm_ctrl
//  Description : Directed vector bench for mm_ctrl with a behavioural
//                multiply-accumulate datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mm_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_ctrl_if #(.OUT_AW(4), .ACC_W(20)) bus ();

    mm_ctrl #(.OUT_AW(4), .ACC_W(20)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath: accumulates one product per cycle, holds the dot product on
    // the cycle its column index equals the column count, then restarts.
    int                 op_a = 0;
    int                 op_b = 0;
    logic [1:0]         dp_idx;
    logic signed [19:0] dp_acc;

    always @(posedge clk or posedge rst) begin
        if (rst || !bus.Mul_Adder_active) begin
            dp_idx <= 2'd0;
            dp_acc <= '0;
        end else if (dp_idx == bus.ma_M1_col_size) begin
            dp_idx <= 2'd0;
            dp_acc <= '0;
        end else begin
            dp_idx <= dp_idx + 2'd1;
            dp_acc <= dp_acc + 20'(op_a * op_b);
        end
    end
    assign bus.ma_col_idx  = dp_idx;
    assign bus.ma_out_data = dp_acc;

    logic [3:0]  wr_addr[$];
    logic [19:0] wr_data[$];
    int done_cnt = 0, err_cnt = 0, act_cnt = 0, size_bad = 0;
    int cur_m1c = 0, cur_m2c = 0;

    always @(negedge clk) begin
        if (bus.out_we) begin
            wr_addr.push_back(bus.out_addr);
            wr_data.push_back(bus.out_wdata);
        end
        if (bus.Mul_Adder_active) begin
            act_cnt++;
            if (int'(bus.ma_M1_col_size) != cur_m1c || int'(bus.ma_M2_col_size) != cur_m2c)
                size_bad++;
        end
        if (bus.done) done_cnt++;
        if (bus.err)  err_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic start_op(input int m1r, input int m1c, input int m2r, input int m2c,
                            input int a, input int b);
        @(negedge clk);
        bus.M1_row_size = 2'(m1r);
        bus.M1_col_size = 2'(m1c);
        bus.M2_row_size = 2'(m2r);
        bus.M2_col_size = 2'(m2c);
        op_a = a;
        op_b = b;
        cur_m1c = m1c;
        cur_m2c = m2c;
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; err_cnt = 0; act_cnt = 0; size_bad = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns on the negedge where done or err is seen; lat counts negedges
    // from the one on which start was driven.
    task automatic wait_end(input string nm, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            if (bus.done || bus.err) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        int m1r, m1c, m2r, m2c, a, b;
        int exp_err, exp_n;
        logic [19:0] exp_data;
        int exp_act, exp_lat;
    } vec_t;

    vec_t vecs[7];
    logic [19:0] sat_exp;

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.M1_row_size = 2'd0;
        bus.M1_col_size = 2'd0;
        bus.M2_row_size = 2'd0;
        bus.M2_col_size = 2'd0;

`ifdef MM_CTRL_SAT_EN
        sat_exp = 20'd32767;
`else
        sat_exp = 20'd48387;
`endif
        //         m1r m1c m2r m2c  a     b    err n  data         act lat
        vecs[0] = '{2, 3, 3, 2,    1,    2,   0, 4, 20'd6,        16, 18};
        vecs[1] = '{1, 1, 1, 1,   -5,    7,   0, 1, 20'hFFFDD,     2,  4};
        vecs[2] = '{2, 2, 3, 1,    1,    1,   1, 0, 20'd0,         0,  1};
        vecs[3] = '{0, 2, 2, 2,    1,    1,   1, 0, 20'd0,         0,  1};
        vecs[4] = '{3, 3, 3, 3,  127,  127,   0, 9, sat_exp,      36, 38};
        vecs[5] = '{3, 1, 1, 3,    2,    3,   0, 9, 20'd6,        18, 20};
        vecs[6] = '{1, 2, 2, 1, -100,    3,   0, 1, 20'hFFDA8,     3,  5};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_outs", {bus.Mul_Adder_active, bus.out_we, bus.done, bus.err,
                         bus.ma_M1_col_size, bus.ma_M2_col_size, bus.out_addr,
                         bus.out_wdata}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_op(vecs[v].m1r, vecs[v].m1c, vecs[v].m2r, vecs[v].m2c, vecs[v].a, vecs[v].b);
            wait_end($sformatf("v%0d", v), lat);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", v), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
            chk($sformatf("v%0d_done", v), done_cnt, 1 - vecs[v].exp_err);
            chk($sformatf("v%0d_nwr", v), wr_addr.size(), vecs[v].exp_n);
            chk($sformatf("v%0d_active", v), act_cnt, vecs[v].exp_act);
            chk($sformatf("v%0d_size_hold", v), size_bad, 0);
            for (int j = 0; j < wr_addr.size(); j++) begin
                chk($sformatf("v%0d_addr%0d", v, j), wr_addr[j], j);
                chk($sformatf("v%0d_data%0d", v, j), wr_data[j], vecs[v].exp_data);
            end
        end

        // start during COMPUTE and during DONE must both be ignored
        start_op(3, 3, 3, 3, 1, 1);
        repeat (10) @(negedge clk);
        bus.M1_row_size = 2'd1; bus.M1_col_size = 2'd1;
        bus.M2_row_size = 2'd1; bus.M2_col_size = 2'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_end("guard", lat);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("guard_busy_after", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("guard_still_idle", {31'd0, bus.busy}, 32'd0);
        chk("guard_nwr", wr_addr.size(), 9);
        chk("guard_done", done_cnt, 1);
        chk("guard_active", act_cnt, 36);
        chk("guard_size_hold", size_bad, 0);
        for (int j = 0; j < wr_addr.size(); j++) begin
            chk($sformatf("guard_addr%0d", j), wr_addr[j], j);
            chk($sformatf("guard_data%0d", j), wr_data[j], 20'd3);
        end

        // reset right after the second write
        start_op(3, 3, 3, 3, 1, 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (wr_addr.size() >= 2) break;
        end
        chk("midrst_two_writes", wr_addr.size(), 2);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_outs", {bus.Mul_Adder_active, bus.out_we, bus.done, bus.err,
                            bus.ma_M1_col_size, bus.ma_M2_col_size, bus.out_addr,
                            bus.out_wdata}, 32'd0);
        @(negedge clk);
        chk("midrst_no_done_err", done_cnt + err_cnt, 0);
        rst = 1'b0;
        start_op(1, 1, 1, 1, 4, 5);
        wait_end("after_rst", lat);
        @(negedge clk);
        chk("after_rst_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("after_rst_addr", wr_addr[0], 0);
            chk("after_rst_data", wr_data[0], 20'd20);
        end
        chk("after_rst_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
